div_sqrt_issue_ctrl_mvp: RTL and testbench
==========================================

// Module: div_sqrt_issue_ctrl_mvp
// PURPOSE
//  Issue/sequencing controller for the iterative div/sqrt unit. Accepts one op via valid/ready and latches
//  op, format, rounding mode and precision control. Drives the iteration datapath for a format-dependent
//  cycle count, then captures the normalise/round stage result and flags into an output register held under
//  valid/ready. Sits between the FPU issue logic and the iteration + normalise/round datapath.
// PARAMETERS
//  ITER_PER_CYCLE  1   quotient/root bits produced per ITER cycle; legal 1..4
//  PREC_W          6   width of precision-control input
// PORTS
//  Clk_CI            in   1       clock
//  Rst_SI            in   1       synchronous active-high reset
//  Kill_SI           in   1       abort in-flight op, discard result
//  In_valid_SI       in   1       request valid
//  In_ready_SO       out  1       request accepted when In_valid_SI & In_ready_SO
//  Sqrt_SI           in   1       0 = divide, 1 = square root
//  Fmt_SI            in   2       00 FP32, 01 FP64, 10 FP16, 11 FP16ALT
//  RM_SI             in   3       rounding mode, latched
//  Prec_ctl_SI       in   PREC_W  requested quotient bits; 0 = full precision
//  Special_SI        in   1       classifier: NaN/Inf/zero operand, no iteration needed
//  Load_SO           out  1       1-cycle pulse on accept: datapath loads operands
//  Iter_en_SO        out  1       datapath iterates this cycle
//  Iter_cnt_DO       out  6       remaining ITER cycles incl. current
//  Div_enable_SO     out  1       latched ~Sqrt; valid while Busy_SO
//  Sqrt_enable_SO    out  1       latched Sqrt; valid while Busy_SO
//  FP32_SO/FP64_SO/FP16_SO/FP16ALT_SO out 1 each  one-hot decoded latched format
//  RM_SO             out  3       latched rounding mode
//  Full_precision_SO out  1       latched: Prec_ctl==0 or Prec_ctl>=Qfull(fmt)
//  Result_DI         in   64      result from normalise/round stage
//  Fflags_DI         in   5       {NV,DZ,OF,UF,NX} from normalise/round stage
//  Out_valid_SO      out  1       Result_DO/Fflags_DO valid
//  Out_ready_SI      in   1       consumer accepts result
//  Result_DO         out  64      registered result
//  Fflags_DO         out  5       registered flags
//  Busy_SO           out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except In_ready_SO=1; latched fields cleared to 0.
//  States: IDLE -> ITER -> NORM -> DONE -> IDLE.
//   IDLE: In_ready_SO = ~Kill_SI. On accept: latch fields, pulse Load_SO,
//         go NORM if Special_SI else ITER with Iter_cnt = N.
//   ITER: Iter_en_SO=1; Iter_cnt decrements each cycle; at Iter_cnt==1 go NORM.
//   NORM: one cycle; register Result_DI/Fflags_DI; go DONE with Out_valid_SO=1 next cycle.
//   DONE: hold Result_DO/Fflags_DO/Out_valid_SO stable until Out_ready_SI=1, then IDLE.
//         No accept in DONE (In_ready_SO=0): single op in flight.
//  Qfull(fmt) = mantissa+hidden+2 guard bits: FP64 55, FP32 26, FP16 13, FP16ALT 10.
//  Q = Full_precision ? Qfull : Prec_ctl. N = ceil(Q / ITER_PER_CYCLE), minimum 1.
//  Latency, non-special: accept cycle t; Out_valid_SO first high at t+N+2. Special: t+2.
//  Kill_SI: in any state, next cycle is IDLE with Out_valid_SO=0 and Iter_en_SO=0; result is dropped.
//   Kill with In_valid in IDLE: no accept.
//   Kill with Out_ready in DONE: result is treated as dropped; consumer ignores it.
//  Reset mid-op: identical to power-on reset; no result is produced.
//  Out_valid_SO=1 and Out_ready_SI=1 in the same cycle: completes; In_ready_SO rises the next cycle.
//  Latched fields and decoded format are stable from the cycle after accept until return to IDLE.
// TESTING
//  FP64 div, Prec=0, ITER_PER_CYCLE=1, Out_ready=1 -> Load pulse at t, Iter_en high 55 cycles, Out_valid at t+57.
//  FP32 sqrt, Prec=12, ITER_PER_CYCLE=2 -> N=6, Full_precision_SO=0, Sqrt_enable_SO=1, Out_valid at t+8.
//  Special_SI=1, FP16 -> Iter_en never high, Out_valid at t+2, Result_DO/Fflags_DO equal inputs sampled in NORM.
//  Out_ready held low 10 cycles in DONE -> outputs stable, In_ready_SO=0, no new accept.
//  Kill_SI at ITER cnt 20, then In_valid next cycle -> IDLE, Out_valid never asserted, new op accepted.
//  Rst_SI mid-ITER -> next cycle all outputs at reset values, In_ready_SO=1.

Source files
------------

// File: rtl/div_sqrt_issue_ctrl_mvp.sv
// Issue/sequencing controller for the iterative div/sqrt unit: accepts one op,
// runs the iteration datapath for a format-dependent count, and holds the rounded result.
module div_sqrt_issue_ctrl_mvp #(
  parameter int ITER_PER_CYCLE = 1,
  parameter int PREC_W         = 6
) (
  input  logic              Clk_CI,
  input  logic              Rst_SI,
  input  logic              Kill_SI,
  input  logic              In_valid_SI,
  output logic              In_ready_SO,
  input  logic              Sqrt_SI,
  input  logic [1:0]        Fmt_SI,
  input  logic [2:0]        RM_SI,
  input  logic [PREC_W-1:0] Prec_ctl_SI,
  input  logic              Special_SI,
  output logic              Load_SO,
  output logic              Iter_en_SO,
  output logic [5:0]        Iter_cnt_DO,
  output logic              Div_enable_SO,
  output logic              Sqrt_enable_SO,
  output logic              FP32_SO,
  output logic              FP64_SO,
  output logic              FP16_SO,
  output logic              FP16ALT_SO,
  output logic [2:0]        RM_SO,
  output logic              Full_precision_SO,
  input  logic [63:0]       Result_DI,
  input  logic [4:0]        Fflags_DI,
  output logic              Out_valid_SO,
  input  logic              Out_ready_SI,
  output logic [63:0]       Result_DO,
  output logic [4:0]        Fflags_DO,
  output logic              Busy_SO
);

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_e;

  state_e state;
  logic   accept;
  logic   full_prec;
  int     qfull, prec_i, q_i, n_i;

  assign In_ready_SO = (state == IDLE) && !Kill_SI;
  assign accept      = In_valid_SI && In_ready_SO;
  assign Load_SO     = accept;
  assign Busy_SO     = (state != IDLE);

  // Quotient bits per format: mantissa + hidden bit + 2 guard bits.
  always_comb begin
    qfull = 26;
    case (Fmt_SI)
      2'b00: qfull = 26;
      2'b01: qfull = 55;
      2'b10: qfull = 13;
      2'b11: qfull = 10;
      default: qfull = 26;
    endcase
  end

  always_comb begin
    prec_i    = int'(Prec_ctl_SI);
    full_prec = (prec_i == 0) || (prec_i >= qfull);
    q_i       = full_prec ? qfull : prec_i;
    n_i       = (q_i + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    if (n_i < 1) n_i = 1;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_SI) begin
      state             <= IDLE;
      Iter_en_SO        <= 1'b0;
      Iter_cnt_DO       <= '0;
      Div_enable_SO     <= 1'b0;
      Sqrt_enable_SO    <= 1'b0;
      FP32_SO           <= 1'b0;
      FP64_SO           <= 1'b0;
      FP16_SO           <= 1'b0;
      FP16ALT_SO        <= 1'b0;
      RM_SO             <= '0;
      Full_precision_SO <= 1'b0;
      Out_valid_SO      <= 1'b0;
      Result_DO         <= '0;
      Fflags_DO         <= '0;
    end else if (Kill_SI) begin
      // Abort wherever we are; any pending result is simply discarded.
      state        <= IDLE;
      Iter_en_SO   <= 1'b0;
      Iter_cnt_DO  <= '0;
      Out_valid_SO <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          Div_enable_SO     <= !Sqrt_SI;
          Sqrt_enable_SO    <= Sqrt_SI;
          FP32_SO           <= (Fmt_SI == 2'b00);
          FP64_SO           <= (Fmt_SI == 2'b01);
          FP16_SO           <= (Fmt_SI == 2'b10);
          FP16ALT_SO        <= (Fmt_SI == 2'b11);
          RM_SO             <= RM_SI;
          Full_precision_SO <= full_prec;
          if (Special_SI) begin
            state <= NORM;
          end else begin
            state       <= ITER;
            Iter_en_SO  <= 1'b1;
            Iter_cnt_DO <= 6'(n_i);
          end
        end
        ITER: begin
          if (Iter_cnt_DO == 6'd1) begin
            state       <= NORM;
            Iter_en_SO  <= 1'b0;
            Iter_cnt_DO <= '0;
          end else begin
            Iter_cnt_DO <= Iter_cnt_DO - 6'd1;
          end
        end
        NORM: begin
          Result_DO    <= Result_DI;
          Fflags_DO    <= Fflags_DI;
          Out_valid_SO <= 1'b1;
          state        <= DONE;
        end
        DONE: if (Out_ready_SI) begin
          Out_valid_SO <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sqrt_issue_ctrl_mvp.sv
// Directed, table-driven bench for div_sqrt_issue_ctrl_mvp; two instances cover ITER_PER_CYCLE 1 and 2.
module tb_div_sqrt_issue_ctrl_mvp;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst, kill, in_valid, sqrt, special, out_ready;
  logic [1:0]  fmt;
  logic [2:0]  rm;
  logic [5:0]  prec;
  logic [63:0] res_di;
  logic [4:0]  ff_di;

  logic        in_ready1, load1, iter_en1, div_en1, sqrt_en1, fp32_1, fp64_1, fp16_1, fp16alt_1, full1, out_valid1, busy1;
  logic [5:0]  cnt1;
  logic [2:0]  rm1;
  logic [63:0] res1;
  logic [4:0]  ff1;
  logic        in_ready2, load2, iter_en2, div_en2, sqrt_en2, fp32_2, fp64_2, fp16_2, fp16alt_2, full2, out_valid2, busy2;
  logic [5:0]  cnt2;
  logic [2:0]  rm2;
  logic [63:0] res2;
  logic [4:0]  ff2;

  div_sqrt_issue_ctrl_mvp #(.ITER_PER_CYCLE(1), .PREC_W(6)) u_dut (
    .Clk_CI(clk), .Rst_SI(rst), .Kill_SI(kill), .In_valid_SI(in_valid), .In_ready_SO(in_ready1),
    .Sqrt_SI(sqrt), .Fmt_SI(fmt), .RM_SI(rm), .Prec_ctl_SI(prec), .Special_SI(special),
    .Load_SO(load1), .Iter_en_SO(iter_en1), .Iter_cnt_DO(cnt1), .Div_enable_SO(div_en1),
    .Sqrt_enable_SO(sqrt_en1), .FP32_SO(fp32_1), .FP64_SO(fp64_1), .FP16_SO(fp16_1),
    .FP16ALT_SO(fp16alt_1), .RM_SO(rm1), .Full_precision_SO(full1), .Result_DI(res_di),
    .Fflags_DI(ff_di), .Out_valid_SO(out_valid1), .Out_ready_SI(out_ready), .Result_DO(res1),
    .Fflags_DO(ff1), .Busy_SO(busy1));

  div_sqrt_issue_ctrl_mvp #(.ITER_PER_CYCLE(2), .PREC_W(6)) u_dut2 (
    .Clk_CI(clk), .Rst_SI(rst), .Kill_SI(kill), .In_valid_SI(in_valid), .In_ready_SO(in_ready2),
    .Sqrt_SI(sqrt), .Fmt_SI(fmt), .RM_SI(rm), .Prec_ctl_SI(prec), .Special_SI(special),
    .Load_SO(load2), .Iter_en_SO(iter_en2), .Iter_cnt_DO(cnt2), .Div_enable_SO(div_en2),
    .Sqrt_enable_SO(sqrt_en2), .FP32_SO(fp32_2), .FP64_SO(fp64_2), .FP16_SO(fp16_2),
    .FP16ALT_SO(fp16alt_2), .RM_SO(rm2), .Full_precision_SO(full2), .Result_DI(res_di),
    .Fflags_DI(ff_di), .Out_valid_SO(out_valid2), .Out_ready_SI(out_ready), .Result_DO(res2),
    .Fflags_DO(ff2), .Busy_SO(busy2));

  typedef struct {
    logic        sqrt;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [5:0]  prec;
    logic        special;
    logic [63:0] res;
    logic [4:0]  flags;
    int          n1;    // expected iterations at 1 bit/cycle (0 for special)
    int          n2;    // expected iterations at 2 bits/cycle
    logic        full;
    logic [3:0]  oh;    // {FP64, FP32, FP16, FP16ALT}
  } vec_t;

  vec_t vecs[7];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready"}, in_ready1, 1);
    chk({tag, " load"}, load1, 0);
    chk({tag, " iter_en"}, iter_en1, 0);
    chk({tag, " iter_cnt"}, cnt1, 0);
    chk({tag, " div/sqrt en"}, {div_en1, sqrt_en1}, 0);
    chk({tag, " fmt onehot"}, {fp64_1, fp32_1, fp16_1, fp16alt_1}, 0);
    chk({tag, " rm"}, rm1, 0);
    chk({tag, " full_prec"}, full1, 0);
    chk({tag, " out_valid"}, out_valid1, 0);
    chk({tag, " result"}, res1, 0);
    chk({tag, " fflags"}, ff1, 0);
    chk({tag, " busy"}, busy1, 0);
  endtask

  task automatic drive(input vec_t v);
    sqrt = v.sqrt; fmt = v.fmt; rm = v.rm; prec = v.prec; special = v.special;
    res_di = v.res; ff_di = v.flags;
  endtask

  // Caller is at a negedge with both instances idle. hold > 0 keeps Out_ready low
  // in DONE for that many cycles while a new request is offered.
  task automatic run_vec(input string tag, input vec_t v, input int hold);
    int lat1, lat2, iters;
    logic [63:0] held;
    drive(v);
    in_valid = 1;
    #1;
    chk({tag, " load pulse"}, load1, 1);
    chk({tag, " load pulse ipc2"}, load2, 1);
    lat1 = 0; lat2 = 0; iters = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 0;
        chk({tag, " sqrt/div en"}, {sqrt_en1, div_en1}, {v.sqrt, !v.sqrt});
        chk({tag, " fmt onehot"}, {fp64_1, fp32_1, fp16_1, fp16alt_1}, v.oh);
        chk({tag, " rm"}, rm1, v.rm);
        chk({tag, " full_prec"}, full1, v.full);
        chk({tag, " iter_cnt"}, cnt1, v.n1);
        chk({tag, " iter_cnt ipc2"}, cnt2, v.n2);
        chk({tag, " busy"}, busy1, 1);
      end
      if (iter_en1) iters++;
      if (lat1 == 0 && out_valid1) lat1 = k;
      if (lat2 == 0 && out_valid2) lat2 = k;
      if (lat1 != 0 && lat2 != 0) break;
    end
    chk({tag, " latency"}, lat1, v.special ? 2 : v.n1 + 2);
    chk({tag, " latency ipc2"}, lat2, v.special ? 2 : v.n2 + 2);
    chk({tag, " iter cycles"}, iters, v.n1);
    chk({tag, " result"}, res1, v.res);
    chk({tag, " fflags"}, ff1, v.flags);
    chk({tag, " in_ready in DONE"}, in_ready1, 0);
    held = res1;
    if (hold > 0) begin
      in_valid = 1;
      res_di = ~v.res;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, " hold out_valid"}, out_valid1, 1);
        chk({tag, " hold result"}, res1, held);
        chk({tag, " hold in_ready"}, in_ready1, 0);
        chk({tag, " hold load"}, load1, 0);
      end
      in_valid = 0;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, " out_valid after ready"}, out_valid1, 0);
    chk({tag, " in_ready after ready"}, in_ready1, 1);
    chk({tag, " in_ready ipc2 after ready"}, in_ready2, 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b01, 3'd0, 6'd0,  1'b0, 64'h1111_2222_3333_4444, 5'h01, 55, 28, 1'b1, 4'b1000};
    vecs[1] = '{1'b1, 2'b00, 3'd3, 6'd12, 1'b0, 64'h0000_0000_3f80_0000, 5'h00, 12, 6,  1'b0, 4'b0100};
    vecs[2] = '{1'b0, 2'b10, 3'd1, 6'd0,  1'b1, 64'h0000_0000_0000_7e00, 5'h10, 0,  0,  1'b1, 4'b0010};
    vecs[3] = '{1'b0, 2'b11, 3'd4, 6'd10, 1'b0, 64'hdead_beef_0000_3f80, 5'h03, 10, 5,  1'b1, 4'b0001};
    vecs[4] = '{1'b1, 2'b10, 3'd2, 6'd7,  1'b0, 64'h0000_0000_0000_3c00, 5'h08, 7,  4,  1'b0, 4'b0010};
    vecs[5] = '{1'b0, 2'b00, 3'd7, 6'd40, 1'b0, 64'h0123_4567_89ab_cdef, 5'h04, 26, 13, 1'b1, 4'b0100};
    vecs[6] = '{1'b1, 2'b01, 3'd5, 6'd1,  1'b0, 64'hffff_0000_ffff_0000, 5'h02, 1,  1,  1'b0, 4'b1000};

    rst = 1; kill = 0; in_valid = 0; out_ready = 0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // Result held in DONE while a new request is offered.
    run_vec("done_hold", vecs[2], 10);

    // Kill alongside a request in IDLE: nothing accepted.
    drive(vecs[0]);
    kill = 1; in_valid = 1;
    #1;
    chk("kill_idle in_ready", in_ready1, 0);
    chk("kill_idle load", load1, 0);
    @(negedge clk);
    kill = 0; in_valid = 0;
    chk("kill_idle busy", busy1, 0);

    // Kill mid-iteration at count 20, then a fresh op right after.
    begin
      int seen_valid, reached;
      seen_valid = 0; reached = 0;
      drive(vecs[0]);
      in_valid = 1;
      for (int k = 1; k <= 80; k++) begin
        @(negedge clk);
        in_valid = 0;
        if (out_valid1) seen_valid++;
        if (cnt1 == 6'd20) begin reached = 1; break; end
      end
      chk("kill_iter reached cnt20", reached, 1);
      kill = 1;
      @(negedge clk);
      kill = 0;
      if (out_valid1) seen_valid++;
      chk("kill_iter busy", busy1, 0);
      chk("kill_iter iter_en", iter_en1, 0);
      chk("kill_iter out_valid never", seen_valid, 0);
      chk("kill_iter ipc2 idle", {busy2, out_valid2}, 0);
      run_vec("after_kill", vecs[1], 0);
    end

    // Out_ready already high when the result appears: completes in one cycle.
    drive(vecs[2]);
    out_ready = 1; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("same_cycle k1 out_valid", out_valid1, 0);
    @(negedge clk);
    chk("same_cycle k2 out_valid", out_valid1, 1);
    chk("same_cycle k2 in_ready", in_ready1, 0);
    @(negedge clk);
    chk("same_cycle k3 out_valid", out_valid1, 0);
    chk("same_cycle k3 in_ready", in_ready1, 1);
    out_ready = 0;

    // Reset during iteration behaves like power-on reset.
    drive(vecs[5]);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    chk("midrst iterating", iter_en1, 1);
    rst = 1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 0;
    repeat (30) @(negedge clk);
    chk("midrst no result", out_valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
